// File: rtl/triad_decode_array_pkg.sv
// Shared definitions for the triad decoder array: FSM states, triad framing and nibble decode.
package triad_decode_array_pkg;

   localparam int TRIAD_LEN   = 3;
   localparam int DISCARD_LEN = TRIAD_LEN - 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BIT1,
      ST_BIT2,
      ST_HOLD,
      ST_DISCARD
   } state_t;

   function automatic logic [3:0] nib_onehot(input logic [1:0] sel);
      nib_onehot = 4'b0001 << sel;
   endfunction

endpackage

// File: rtl/triad_decode_array_if.sv
// Triad decoder bus: serial triad inputs, persistence/counter controls, hit map and readback outputs.
interface triad_decode_array_if #(
   parameter int NCH       = 8,
   parameter int PERSIST_W = 4,
   parameter int CNT_W     = 16,
   parameter int SEL_W     = 5
);
   logic [NCH-1:0]       triad;
   logic [PERSIST_W-1:0] persist;
   logic                 persist1;
   logic                 cnt_rst;
   logic [SEL_W-1:0]     cnt_sel;
   logic [4*NCH-1:0]     h_strip;
   logic [NCH-1:0]       triad_skip;
   logic                 skip_any;
   logic [NCH-1:0]       busy;
   logic [CNT_W-1:0]     hit_cnt;
   logic [CNT_W-1:0]     skip_cnt;

   modport master (
      output triad, persist, persist1, cnt_rst, cnt_sel,
      input  h_strip, triad_skip, skip_any, busy, hit_cnt, skip_cnt
   );

   modport slave (
      input  triad, persist, persist1, cnt_rst, cnt_sel,
      output h_strip, triad_skip, skip_any, busy, hit_cnt, skip_cnt
   );
endinterface

// File: rtl/triad_decode_array_chan.sv
// One distrip channel: triad FSM with persistence hold, skip/discard handling and saturating counters.
module triad_chan
   import triad_decode_array_pkg::*;
#(
   parameter int PERSIST_W = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_triad,
   input  logic [PERSIST_W-1:0] i_persist,
   input  logic                 i_persist1,
   input  logic                 i_cnt_rst,
   output logic [3:0]           o_hit,
   output logic                 o_skip,
   output logic                 o_busy,
   output logic [CNT_W-1:0]     o_hit_cnt,
   output logic [CNT_W-1:0]     o_skip_cnt
);
   state_t               r_state;
   logic                 r_s;
   logic [PERSIST_W-1:0] r_hold;
   logic [1:0]           r_disc;
   logic [3:0]           r_hit;
   logic                 r_skip;
   logic [CNT_W-1:0]     r_hit_cnt;
   logic [CNT_W-1:0]     r_skip_cnt;
   logic                 w_hit_inc;
   logic                 w_skip_inc;

   // Pending discard bits are consumed first, so a bit already marked for discard never raises a second skip.
   always_comb begin
      w_hit_inc  = (r_state == ST_BIT2);
      w_skip_inc = (r_state == ST_HOLD) && (r_disc == 2'd0) && (r_hold != '0) && i_triad;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_s     <= 1'b0;
         r_hold  <= '0;
         r_disc  <= '0;
         r_hit   <= '0;
         r_skip  <= 1'b0;
      end else begin
         r_skip <= w_skip_inc;
         case (r_state)
            ST_IDLE: begin
               if (i_triad) r_state <= ST_BIT1;
            end
            ST_BIT1: begin
               r_s     <= i_triad;
               r_state <= ST_BIT2;
            end
            ST_BIT2: begin
               r_hold  <= i_persist1 ? '0 : i_persist;
               r_hit   <= nib_onehot({r_s, i_triad});
               r_state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (r_disc != 2'd0)  r_disc <= r_disc - 2'd1;
               else if (w_skip_inc) r_disc <= 2'(DISCARD_LEN);
               if (r_hold != '0) begin
                  r_hold <= r_hold - PERSIST_W'(1);
               end else begin
                  // Last hold cycle: a start bit here is legal unless it is still owed to a discard.
                  r_hit <= '0;
                  if (r_disc > 2'd1)                    r_state <= ST_DISCARD;
                  else if (r_disc == 2'd0 && i_triad)   r_state <= ST_BIT1;
                  else                                  r_state <= ST_IDLE;
               end
            end
            ST_DISCARD: begin
               r_disc <= r_disc - 2'd1;
               if (r_disc <= 2'd1) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || i_cnt_rst) begin
         r_hit_cnt  <= '0;
         r_skip_cnt <= '0;
      end else begin
         if (w_hit_inc && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
         if (w_skip_inc && (r_skip_cnt != '1)) r_skip_cnt <= r_skip_cnt + CNT_W'(1);
      end
   end

   assign o_hit      = r_hit;
   assign o_skip     = r_skip;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_hit_cnt  = r_hit_cnt;
   assign o_skip_cnt = r_skip_cnt;

endmodule

// File: rtl/triad_decode_array.sv
// NCH independent triad decoders producing a 4*NCH half-strip hit map, with skip summary and counter readback.
module triad_decode_array
   import triad_decode_array_pkg::*;
#(
   parameter int NCH       = 8,
   parameter int PERSIST_W = 4,
   parameter int CNT_W     = 16,
   parameter int SEL_W     = 5
) (
   input logic                  clk,
   input logic                  reset,
   triad_decode_array_if.slave  bus
);
   logic [4*NCH-1:0] w_h_strip;
   logic [NCH-1:0]   w_skip;
   logic [NCH-1:0]   w_busy;
   logic [CNT_W-1:0] w_hit_cnt  [NCH];
   logic [CNT_W-1:0] w_skip_cnt [NCH];
   logic [CNT_W-1:0] w_sel_hit;
   logic [CNT_W-1:0] w_sel_skip;
   logic             r_skip_any;
   logic [CNT_W-1:0] r_hit_cnt;
   logic [CNT_W-1:0] r_skip_cnt;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      triad_chan #(
         .PERSIST_W (PERSIST_W),
         .CNT_W     (CNT_W)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .i_triad    (bus.triad[i]),
         .i_persist  (bus.persist),
         .i_persist1 (bus.persist1),
         .i_cnt_rst  (bus.cnt_rst),
         .o_hit      (w_h_strip[4*i +: 4]),
         .o_skip     (w_skip[i]),
         .o_busy     (w_busy[i]),
         .o_hit_cnt  (w_hit_cnt[i]),
         .o_skip_cnt (w_skip_cnt[i])
      );
   end

   // Compare-based select so an out-of-range cnt_sel naturally yields zero.
   always_comb begin
      w_sel_hit  = '0;
      w_sel_skip = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (bus.cnt_sel == SEL_W'(k)) begin
            w_sel_hit  = w_hit_cnt[k];
            w_sel_skip = w_skip_cnt[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_skip_any <= 1'b0;
         r_hit_cnt  <= '0;
         r_skip_cnt <= '0;
      end else begin
         r_skip_any <= |w_skip;
         r_hit_cnt  <= w_sel_hit;
         r_skip_cnt <= w_sel_skip;
      end
   end

   assign bus.h_strip    = w_h_strip;
   assign bus.triad_skip = w_skip;
   assign bus.skip_any   = r_skip_any;
   assign bus.busy       = w_busy;
   assign bus.hit_cnt    = r_hit_cnt;
   assign bus.skip_cnt   = r_skip_cnt;

endmodule

// File: tb/tb_triad_decode_array.sv
// Self-checking bench for triad_decode_array: directed vector table, hand sequences and a random run against a reference model.
module tb_triad_decode_array;

   localparam int NCH = 8;
   localparam int PW  = 4;
   localparam int CW  = 16;
   localparam int SW  = 5;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   triad_decode_array_if #(.NCH(NCH), .PERSIST_W(PW), .CNT_W(CW), .SEL_W(SW)) bus ();
   triad_decode_array #(.NCH(NCH), .PERSIST_W(PW), .CNT_W(CW), .SEL_W(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Narrow-counter instance so saturation is reachable in a few dozen triads.
   triad_decode_array_if #(.NCH(2), .PERSIST_W(PW), .CNT_W(4), .SEL_W(1)) sbus ();
   triad_decode_array #(.NCH(2), .PERSIST_W(PW), .CNT_W(4), .SEL_W(1)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (sbus)
   );

   typedef struct {
      int         ch;
      logic       s;
      logic       h;
      logic [3:0] p;
      logic       p1;
      int         bit_idx;
      int         n;
   } vec_t;

   vec_t vecs [5];

   // reference model state
   int               m_ph   [NCH];
   int               m_s    [NCH];
   int               m_left [NCH];
   int               m_dis  [NCH];
   int               m_idx  [NCH];
   int               m_hc   [NCH];
   int               m_sc   [NCH];
   logic [NCH-1:0]   m_skip;
   logic [4*NCH-1:0] exp_h;
   logic [NCH-1:0]   exp_busy;
   logic             exp_any;
   int               exp_hc;
   int               exp_sc;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_seq(input string name, input int ch, input logic [3:0] p, input logic p1,
                          input logic [15:0] bits, input logic [63:0] nib, input logic [15:0] skp);
      bus.persist  = p;
      bus.persist1 = p1;
      for (int k = 0; k < 16; k++) begin
         bus.triad[ch] = bits[k];
         tick();
         chk({name, "_hit"}, 64'(bus.h_strip[4*ch +: 4]), 64'(nib[4*k +: 4]));
         chk({name, "_skip"}, 64'(bus.triad_skip[ch]), 64'(skp[k]));
         if (k > 0) chk({name, "_any"}, 64'(bus.skip_any), 64'(skp[k-1]));
      end
      bus.triad = '0;
   endtask

   function automatic void model_clear();
      for (int c = 0; c < NCH; c++) begin
         m_ph[c] = 0; m_s[c] = 0; m_left[c] = 0; m_dis[c] = 0;
         m_idx[c] = 0; m_hc[c] = 0; m_sc[c] = 0;
      end
      m_skip = '0;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   function automatic void model_step();
      int sel;
      sel     = int'(bus.cnt_sel);
      exp_hc  = (sel < NCH) ? m_hc[sel] : 0;
      exp_sc  = (sel < NCH) ? m_sc[sel] : 0;
      exp_any = |m_skip;
      for (int c = 0; c < NCH; c++) begin
         logic t;
         t = bus.triad[c];
         m_skip[c] = 1'b0;
         if (m_left[c] > 0) begin
            if (m_dis[c] > 0) m_dis[c]--;
            else if (t && m_left[c] > 1) begin
               m_skip[c] = 1'b1;
               m_dis[c]  = 2;
               if (m_sc[c] < 65535) m_sc[c]++;
            end else if (t) m_ph[c] = 1;
            m_left[c]--;
         end else if (m_dis[c] > 0) begin
            m_dis[c]--;
         end else if (m_ph[c] == 0) begin
            m_ph[c] = t ? 1 : 0;
         end else if (m_ph[c] == 1) begin
            m_s[c]  = t ? 1 : 0;
            m_ph[c] = 2;
         end else begin
            m_idx[c]  = m_s[c] * 2 + (t ? 1 : 0);
            m_left[c] = bus.persist1 ? 1 : int'(bus.persist) + 1;
            m_ph[c]   = 0;
            if (m_hc[c] < 65535) m_hc[c]++;
         end
      end
      if (bus.cnt_rst) begin
         for (int c = 0; c < NCH; c++) begin
            m_hc[c] = 0;
            m_sc[c] = 0;
         end
      end
      exp_h    = '0;
      exp_busy = '0;
      for (int c = 0; c < NCH; c++) begin
         if (m_left[c] > 0) exp_h[4*c + m_idx[c]] = 1'b1;
         exp_busy[c] = (m_left[c] > 0) || (m_dis[c] > 0) || (m_ph[c] != 0);
      end
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt;
      vec_t x;

      bus.triad = '0;    bus.persist = '0;  bus.persist1 = 1'b0;
      bus.cnt_rst = 1'b0; bus.cnt_sel = '0;
      sbus.triad = '0;   sbus.persist = '0; sbus.persist1 = 1'b1;
      sbus.cnt_rst = 1'b0; sbus.cnt_sel = '0;

      vecs[0] = '{0, 1'b1, 1'b0, 4'd5,  1'b0, 2,  6};
      vecs[1] = '{7, 1'b1, 1'b1, 4'd0,  1'b0, 31, 1};
      vecs[2] = '{4, 1'b0, 1'b1, 4'd15, 1'b0, 17, 16};
      vecs[3] = '{2, 1'b0, 1'b0, 4'd3,  1'b1, 8,  1};
      vecs[4] = '{6, 1'b1, 1'b0, 4'd2,  1'b0, 26, 3};

      tick(); tick(); tick();
      chk("rst_h_strip", 64'(bus.h_strip), 64'(0));
      chk("rst_skip", 64'(bus.triad_skip), 64'(0));
      chk("rst_any", 64'(bus.skip_any), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_hit_cnt", 64'(bus.hit_cnt), 64'(0));
      chk("rst_skip_cnt", 64'(bus.skip_cnt), 64'(0));
      reset = 1'b0;

      for (int v = 0; v < 5; v++) begin
         x = vecs[v];
         bus.persist  = x.p;
         bus.persist1 = x.p1;
         bus.triad[x.ch] = 1'b1;  tick();
         bus.triad[x.ch] = x.s;   tick();
         bus.triad[x.ch] = x.h;   tick();
         bus.triad = '0;
         bus.persist  = ~x.p;
         bus.persist1 = ~x.p1;
         chk("vec_first", 64'(bus.h_strip), 64'(1) << x.bit_idx);
         chk("vec_busy_on", 64'(bus.busy), 64'(1) << x.ch);
         cnt = 0;
         while (bus.h_strip[x.bit_idx] === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
         end
         chk("vec_len", 64'(cnt), 64'(x.n));
         chk("vec_clear", 64'(bus.h_strip), 64'(0));
         chk("vec_busy_off", 64'(bus.busy), 64'(0));
         bus.cnt_sel = SW'(x.ch);
         tick();
         chk("vec_hit_cnt", 64'(bus.hit_cnt), 64'(1));
         chk("vec_skip_cnt", 64'(bus.skip_cnt), 64'(0));
      end

      // skip during a long hold: hold unbroken, two trailing ones discarded
      run_seq("skip_long", 3, 4'd5, 1'b0, 16'h0075, 64'h0000_0000_2222_2200, 16'h0010);
      // skip on the penultimate hold cycle: discard runs on past the hold
      run_seq("skip_short", 1, 4'd1, 1'b0, 16'h003F, 64'h0000_0000_0000_8800, 16'h0008);
      // back-to-back triads with single-clock persistence
      run_seq("b2b", 5, 4'd9, 1'b1, 16'h0039, 64'h0000_0000_0080_0100, 16'h0000);
      chk("skip_long_busy", 64'(bus.busy), 64'(0));

      bus.cnt_sel = 5'd3; tick();
      chk("ch3_hit_cnt", 64'(bus.hit_cnt), 64'(1));
      chk("ch3_skip_cnt", 64'(bus.skip_cnt), 64'(1));
      bus.cnt_sel = 5'd1; tick();
      chk("ch1_skip_cnt", 64'(bus.skip_cnt), 64'(1));
      bus.cnt_sel = 5'd5; tick();
      chk("ch5_hit_cnt", 64'(bus.hit_cnt), 64'(2));
      chk("ch5_skip_cnt", 64'(bus.skip_cnt), 64'(0));
      bus.cnt_sel = 5'd9; tick();
      chk("sel_oor_hit", 64'(bus.hit_cnt), 64'(0));
      chk("sel_oor_skip", 64'(bus.skip_cnt), 64'(0));

      // saturation on the 4-bit-counter instance
      for (int i = 0; i < 15; i++) begin
         sbus.triad[0] = 1'b1; tick();
         sbus.triad[0] = 1'b0; tick();
         tick();
      end
      sbus.triad = '0;
      tick(); tick(); tick();
      chk("sat_full", 64'(sbus.hit_cnt), 64'(15));
      sbus.triad[0] = 1'b1; tick();
      sbus.triad[0] = 1'b0; tick(); tick();
      tick(); tick(); tick();
      chk("sat_hold", 64'(sbus.hit_cnt), 64'(15));
      sbus.triad[0] = 1'b1; tick();
      sbus.triad[0] = 1'b1; tick();
      sbus.triad[0] = 1'b0; sbus.cnt_rst = 1'b1; tick();
      sbus.cnt_rst = 1'b0;
      chk("cntrst_h_strip", 64'(sbus.h_strip[3:0]), 64'(4'h4));
      tick();
      chk("cntrst_wins", 64'(sbus.hit_cnt), 64'(0));

      // reset landing on the BIT2 edge of ch1
      bus.cnt_sel = 5'd5;
      bus.triad[1] = 1'b1; tick();
      bus.triad[1] = 1'b0; tick();
      chk("rst2_busy_pre", 64'(bus.busy[1]), 64'(1));
      chk("rst2_cnt_pre", 64'(bus.hit_cnt), 64'(2));
      bus.triad[1] = 1'b1; reset = 1'b1; tick();
      chk("rst2_h_strip", 64'(bus.h_strip), 64'(0));
      chk("rst2_busy", 64'(bus.busy), 64'(0));
      chk("rst2_hit_cnt", 64'(bus.hit_cnt), 64'(0));
      reset = 1'b0; bus.triad = '0;
      tick(); tick(); tick();
      chk("rst2_aborted", 64'(bus.h_strip), 64'(0));
      for (int c = 0; c < NCH; c++) begin
         bus.cnt_sel = SW'(c); tick();
         chk("rst2_cnt_clear", 64'({bus.hit_cnt, bus.skip_cnt}), 64'(0));
      end

      // random traffic on all channels against the model
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      model_clear();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bus.triad = (cyc < 1500) ? NCH'($urandom & $urandom) : NCH'($urandom);
         if ($urandom_range(0, 63) == 0) bus.persist = PW'($urandom);
         bus.persist1 = ($urandom_range(0, 15) == 0);
         bus.cnt_sel  = SW'($urandom_range(0, 9));
         bus.cnt_rst  = ($urandom_range(0, 499) == 0);
         model_step();
         tick();
         chk("rnd_h_strip", 64'(bus.h_strip), 64'(exp_h));
         chk("rnd_skip", 64'(bus.triad_skip), 64'(m_skip));
         chk("rnd_any", 64'(bus.skip_any), 64'(exp_any));
         chk("rnd_busy", 64'(bus.busy), 64'(exp_busy));
         chk("rnd_hit_cnt", 64'(bus.hit_cnt), 64'(exp_hc));
         chk("rnd_skip_cnt", 64'(bus.skip_cnt), 64'(exp_sc));
      end
      bus.cnt_rst = 1'b0;
      bus.triad   = '0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
